alt_pll_pll: RTL and testbench

Synthesizable clock-generator block standing in for the vendor PLL inside the PLL wrapper. It derives two divided, duty-cycle-controlled, phase-offset clock outputs (`c0`, `c1`) from the reference clock `clk`. Both outputs are held low until an internal lock counter expires, and `locked` reports when they are valid. The wrapper uses `locked` to release its downstream reset request.

---
 rtl/alt_pll_pkg.sv | 19 +
 rtl/pll_clk_div.sv | 43 ++++
 rtl/alt_pll_pll.sv | 67 ++++++
 tb/tb_alt_pll_pll.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/alt_pll_pkg.sv
// Shared constants and sizing helpers for the synthesizable PLL stand-in.
package alt_pll_pkg;

  localparam int unsigned DefC0Div      = 2;
  localparam int unsigned DefC1Div      = 4;
  localparam int unsigned DefC1Phase    = 1;
  localparam int unsigned DefLockCycles = 16;

  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int unsigned high_cnt(input int unsigned n);
    return n / 2;
  endfunction

endpackage

// File: rtl/pll_clk_div.sv
// Enable-gated divider producing a registered clock with floor(DIV/2) high cycles
// and a fixed phase offset set by the counter's reset value.
module pll_clk_div
  import alt_pll_pkg::*;
#(
  parameter int unsigned DIV   = DefC0Div,
  parameter int unsigned PHASE = 0
) (
  input  logic clk,
  input  logic areset_n,
  input  logic en,
  output logic clk_out
);

  if (DIV < 2) begin : g_bad_div
    $error("pll_clk_div: DIV must be >= 2");
  end
  if (PHASE >= DIV) begin : g_bad_phase
    $error("pll_clk_div: PHASE must be < DIV");
  end

  localparam int unsigned CntW = cnt_width(DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);
  localparam logic [CntW-1:0] CntHigh = CntW'(high_cnt(DIV));
  // Starting PHASE counts before zero delays the first rising edge by PHASE cycles.
  localparam logic [CntW-1:0] CntRst = (DIV == 0) ? '0 : CntW'((DIV - PHASE) % DIV);

  logic [CntW-1:0] r_cnt;
  logic            r_clk_out;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_cnt     <= CntRst;
      r_clk_out <= 1'b0;
    end else if (en) begin
      r_cnt     <= (r_cnt == CntMax) ? '0 : r_cnt + 1'b1;
      r_clk_out <= (r_cnt < CntHigh);
    end
  end

  assign clk_out = r_clk_out;

endmodule

// File: rtl/alt_pll_pll.sv
// PLL stand-in: lock counter gates two phase-related clock dividers; locked is
// sticky until reset.
module alt_pll_pll
  import alt_pll_pkg::*;
#(
  parameter int unsigned C0_DIV      = DefC0Div,
  parameter int unsigned C1_DIV      = DefC1Div,
  parameter int unsigned C1_PHASE    = DefC1Phase,
  parameter int unsigned LOCK_CYCLES = DefLockCycles
) (
  input  logic clk,
  input  logic areset_n,
  output logic c0,
  output logic c1,
  output logic locked
);

  if (LOCK_CYCLES < 1) begin : g_bad_lock
    $error("alt_pll_pll: LOCK_CYCLES must be >= 1");
  end

  localparam int unsigned LockW = cnt_width(LOCK_CYCLES + 1);
  localparam logic [LockW-1:0] LockMax = LockW'(LOCK_CYCLES);

  logic [LockW-1:0] r_lock_cnt;
  logic             r_locked;
  logic             w_c0;
  logic             w_c1;

  // Counter saturates at LockMax, so locked can only ever be set once per reset.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
    end else if (r_lock_cnt != LockMax) begin
      r_lock_cnt <= r_lock_cnt + 1'b1;
      if (r_lock_cnt == LockMax - 1'b1) begin
        r_locked <= 1'b1;
      end
    end
  end

  pll_clk_div #(
    .DIV   (C0_DIV),
    .PHASE (0)
  ) u_div0 (
    .clk      (clk),
    .areset_n (areset_n),
    .en       (r_locked),
    .clk_out  (w_c0)
  );

  pll_clk_div #(
    .DIV   (C1_DIV),
    .PHASE (C1_PHASE)
  ) u_div1 (
    .clk      (clk),
    .areset_n (areset_n),
    .en       (r_locked),
    .clk_out  (w_c1)
  );

  assign c0     = w_c0;
  assign c1     = w_c1;
  assign locked = r_locked;

endmodule

// File: tb/tb_alt_pll_pll.sv
// Directed bench: default, zero-phase, odd-divider and a DIV 2..9 sweep of alt_pll_pll.
module tb_alt_pll_pll;

  logic clk;
  logic areset_n;

  logic def_c0, def_c1, def_lk;
  logic zp_c0, zp_c1, zp_lk;
  logic odd_c0, odd_c1, odd_lk;
  logic [7:0] sw_c0, sw_c1, sw_lk;

  int n_checks;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alt_pll_pll u_def (
    .clk      (clk),
    .areset_n (areset_n),
    .c0       (def_c0),
    .c1       (def_c1),
    .locked   (def_lk)
  );

  alt_pll_pll #(
    .C0_DIV      (2),
    .C1_DIV      (4),
    .C1_PHASE    (0),
    .LOCK_CYCLES (16)
  ) u_zp (
    .clk      (clk),
    .areset_n (areset_n),
    .c0       (zp_c0),
    .c1       (zp_c1),
    .locked   (zp_lk)
  );

  alt_pll_pll #(
    .C0_DIV      (5),
    .LOCK_CYCLES (1)
  ) u_odd (
    .clk      (clk),
    .areset_n (areset_n),
    .c0       (odd_c0),
    .c1       (odd_c1),
    .locked   (odd_lk)
  );

  function automatic int sw_div(input int i);
    return i + 2;
  endfunction

  function automatic int sw_phase(input int i);
    return (i * 5) % (i + 2);
  endfunction

  for (genvar gi = 0; gi < 8; gi++) begin : g_sw
    alt_pll_pll #(
      .C0_DIV      (gi + 2),
      .C1_DIV      (gi + 2),
      .C1_PHASE    ((gi * 5) % (gi + 2)),
      .LOCK_CYCLES (3)
    ) u_sw (
      .clk      (clk),
      .areset_n (areset_n),
      .c0       (sw_c0[gi]),
      .c1       (sw_c1[gi]),
      .locked   (sw_lk[gi])
    );
  end

  // Expected output after edge k: counter starts at (d-p) mod d and advances once locked.
  function automatic logic exp_clk(input int k, input int lock, input int d, input int p);
    int m;
    if (k <= lock) return 1'b0;
    m = k - lock - 1;
    return (((m + d - p) % d) < (d / 2));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0]  def_c0_tab, def_c1_tab, def_lk_tab, zp_c1_tab;
  logic [11:0] odd_tab;

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    // bit i holds the value after edge 15+i
    def_c0_tab = 8'b0101_0100;
    def_c1_tab = 8'b1001_1000;
    def_lk_tab = 8'b1111_1110;
    zp_c1_tab  = 8'b1100_1100;
    // bit i holds the value after edge i+1
    odd_tab    = 12'h8C6;

    areset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_c0", {31'd0, def_c0}, 32'd0);
    check("rst_c1", {31'd0, def_c1}, 32'd0);
    check("rst_locked", {31'd0, def_lk}, 32'd0);
    check("rst_odd_c0", {31'd0, odd_c0}, 32'd0);
    areset_n = 1'b1;

    for (int k = 1; k <= 29; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k <= 14) begin
        check($sformatf("def_c0@%0d", k), {31'd0, def_c0}, 32'd0);
        check($sformatf("def_c1@%0d", k), {31'd0, def_c1}, 32'd0);
        check($sformatf("def_lk@%0d", k), {31'd0, def_lk}, 32'd0);
      end else if (k <= 22) begin
        check($sformatf("def_c0@%0d", k), {31'd0, def_c0}, {31'd0, def_c0_tab[k-15]});
        check($sformatf("def_c1@%0d", k), {31'd0, def_c1}, {31'd0, def_c1_tab[k-15]});
        check($sformatf("def_lk@%0d", k), {31'd0, def_lk}, {31'd0, def_lk_tab[k-15]});
        check($sformatf("zp_c0@%0d", k), {31'd0, zp_c0}, {31'd0, def_c0_tab[k-15]});
        check($sformatf("zp_c1@%0d", k), {31'd0, zp_c1}, {31'd0, zp_c1_tab[k-15]});
      end
      if (k <= 12) begin
        check($sformatf("odd_c0@%0d", k), {31'd0, odd_c0}, {31'd0, odd_tab[k-1]});
        check($sformatf("odd_lk@%0d", k), {31'd0, odd_lk}, 32'd1);
      end
      for (int i = 0; i < 8; i++) begin
        check($sformatf("sw%0d_c0@%0d", i, k), {31'd0, sw_c0[i]},
              {31'd0, exp_clk(k, 3, sw_div(i), 0)});
        check($sformatf("sw%0d_c1@%0d", i, k), {31'd0, sw_c1[i]},
              {31'd0, exp_clk(k, 3, sw_div(i), sw_phase(i))});
        check($sformatf("sw%0d_lk@%0d", i, k), {31'd0, sw_lk[i]}, {31'd0, (k >= 3)});
      end
    end

    // Mid-run reset while c0 is high; the clear must not wait for a clock edge.
    check("pre_reset_c0", {31'd0, def_c0}, 32'd1);
    areset_n = 1'b0;
    #1;
    check("async_c0", {31'd0, def_c0}, 32'd0);
    check("async_c1", {31'd0, def_c1}, 32'd0);
    check("async_locked", {31'd0, def_lk}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    areset_n = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 15) begin
        check("relock_lk@15", {31'd0, def_lk}, 32'd0);
        check("relock_c0@15", {31'd0, def_c0}, 32'd0);
      end else if (k == 16) begin
        check("relock_lk@16", {31'd0, def_lk}, 32'd1);
        check("relock_c0@16", {31'd0, def_c0}, 32'd0);
      end else if (k == 17) begin
        check("relock_c0@17", {31'd0, def_c0}, 32'd1);
        check("relock_c1@17", {31'd0, def_c1}, 32'd0);
      end else if (k == 18) begin
        check("relock_c0@18", {31'd0, def_c0}, 32'd0);
        check("relock_c1@18", {31'd0, def_c1}, 32'd1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
